// File: rtl/fft_arith_pkg.sv
// fft_arith_pkg: shared arithmetic definitions for the FFT datapath.
//   - divider FSM state encodings (IDLE, CALC, SIGN, DONE)
//   - saturation bit patterns as functions of word length
//   - counter width helper
package fft_arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_SIGN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Largest positive signed wl-bit value, as a zero-extended bit pattern.
  function automatic logic [63:0] sat_max(input int unsigned wl);
    return (64'd1 << (wl - 1)) - 64'd1;
  endfunction

  // Most negative signed wl-bit value; only the low wl bits are meaningful.
  function automatic logic [63:0] sat_min(input int unsigned wl);
    return 64'd1 << (wl - 1);
  endfunction

  // Width of a counter that must hold the values 0..wl.
  function automatic int unsigned cnt_width(input int unsigned wl);
    return int'($clog2(wl + 1));
  endfunction

endpackage

// File: rtl/fft_seq_div_if.sv
// fft_seq_div_if: operand/result handshake bundle for fft_seq_div.
//   in_valid/in_ready + N (2*WL) + D (WL)          : operation request
//   out_valid/out_ready + Q, R (WL) + div_by_zero, overflow : result
// master = requester/consumer side, slave = divider side.
interface fft_seq_div_if #(parameter int WL = 16);
  logic              in_valid;
  logic              in_ready;
  logic [2*WL-1:0]   N;
  logic [WL-1:0]     D;
  logic              out_valid;
  logic              out_ready;
  logic [WL-1:0]     Q;
  logic [WL-1:0]     R;
  logic              div_by_zero;
  logic              overflow;

  modport master (
    output in_valid, N, D, out_ready,
    input  in_ready, out_valid, Q, R, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, N, D, out_ready,
    output in_ready, out_valid, Q, R, div_by_zero, overflow
  );
endinterface

// File: rtl/fft_seq_div_step.sv
// div_step: one combinational restoring division step.
//   rem_in  : partial remainder (always < d)
//   dbit    : next dividend bit shifted in at the LSB
//   d       : unsigned divisor magnitude
//   rem_out : remainder after the conditional subtract
//   q_bit   : quotient bit produced by this step
module div_step #(parameter int WL = 16) (
  input  logic [WL-1:0] rem_in,
  input  logic          dbit,
  input  logic [WL-1:0] d,
  output logic [WL-1:0] rem_out,
  output logic          q_bit
);
  // One extra bit holds the shifted remainder before the compare.
  logic [WL:0] trial;

  always_comb begin
    trial   = {rem_in, dbit};
    q_bit   = (trial >= {1'b0, d});
    // The kept result is always < d, so it fits back into WL bits.
    rem_out = WL'(q_bit ? (trial - {1'b0, d}) : trial);
  end
endmodule

// File: rtl/fft_seq_div.sv
// fft_seq_div: sequential signed divider, 2*WL-bit dividend by WL-bit divisor.
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset
//   bus : fft_seq_div_if.slave (request N/D, result Q/R/div_by_zero/overflow)
// One restoring step per clock; saturates Q and zeroes R on divide-by-zero or
// when the quotient does not fit in signed WL bits.
module fft_seq_div
  import fft_arith_pkg::*;
#(parameter int WL = 16) (
  input  logic CLK,
  input  logic RST,
  fft_seq_div_if.slave bus
);
  localparam int unsigned   CW      = cnt_width(WL);
  localparam logic [WL-1:0] SAT_MAX = WL'(sat_max(WL));
  localparam logic [WL-1:0] SAT_MIN = WL'(sat_min(WL));

  logic [1:0]      state;
  logic            sn, sd;
  logic [WL-1:0]   dabs;
  logic [WL-1:0]   rem;
  logic [WL-1:0]   shreg;
  logic [WL-1:0]   qreg;
  logic [CW-1:0]   cnt;
  logic            out_valid_r, dz_r, ov_r;
  logic [WL-1:0]   q_r, r_r;

  logic            n_neg, d_neg;
  logic [2*WL-1:0] n_abs;
  logic [WL-1:0]   d_abs;
  logic [WL-1:0]   step_rem;
  logic            step_q;
  logic            q_neg;

  always_comb begin
    n_neg = bus.N[2*WL-1];
    d_neg = bus.D[WL-1];
    n_abs = n_neg ? -bus.N : bus.N;
    d_abs = d_neg ? -bus.D : bus.D;
    q_neg = sn ^ sd;
  end

  div_step #(.WL(WL)) u_step (
    .rem_in  (rem),
    .dbit    (shreg[WL-1]),
    .d       (dabs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign bus.in_ready    = (state == ST_IDLE);
  assign bus.out_valid   = out_valid_r;
  assign bus.Q           = q_r;
  assign bus.R           = r_r;
  assign bus.div_by_zero = dz_r;
  assign bus.overflow    = ov_r;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      sn          <= 1'b0;
      sd          <= 1'b0;
      dabs        <= '0;
      rem         <= '0;
      shreg       <= '0;
      qreg        <= '0;
      cnt         <= '0;
      out_valid_r <= 1'b0;
      dz_r        <= 1'b0;
      ov_r        <= 1'b0;
      q_r         <= '0;
      r_r         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            sn    <= n_neg;
            sd    <= d_neg;
            dabs  <= d_abs;
            rem   <= n_abs[2*WL-1:WL];
            shreg <= n_abs[WL-1:0];
            qreg  <= '0;
            cnt   <= '0;
            if (d_abs == '0) begin
              dz_r        <= 1'b1;
              ov_r        <= 1'b0;
              q_r         <= n_neg ? SAT_MIN : SAT_MAX;
              r_r         <= '0;
              out_valid_r <= 1'b1;
              state       <= ST_DONE;
            end else if (n_abs[2*WL-1:WL] >= d_abs) begin
              // Upper half alone already needs more than WL quotient bits.
              dz_r        <= 1'b0;
              ov_r        <= 1'b1;
              q_r         <= (n_neg ^ d_neg) ? SAT_MIN : SAT_MAX;
              r_r         <= '0;
              out_valid_r <= 1'b1;
              state       <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem   <= step_rem;
          shreg <= {shreg[WL-2:0], 1'b0};
          qreg  <= {qreg[WL-2:0], step_q};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WL - 1)) state <= ST_SIGN;
        end
        ST_SIGN: begin
          dz_r        <= 1'b0;
          out_valid_r <= 1'b1;
          state       <= ST_DONE;
          // Unsigned magnitude 2^(WL-1) is legal only for a negative result.
          if (!q_neg && qreg[WL-1]) begin
            ov_r <= 1'b1;
            q_r  <= SAT_MAX;
            r_r  <= '0;
          end else if (q_neg && (qreg > SAT_MIN)) begin
            ov_r <= 1'b1;
            q_r  <= SAT_MIN;
            r_r  <= '0;
          end else begin
            ov_r <= 1'b0;
            q_r  <= q_neg ? -qreg : qreg;
            r_r  <= sn ? -rem : rem;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_seq_div.sv
// tb_fft_seq_div: directed self-checking bench for fft_seq_div (WL = 16).
module tb_fft_seq_div;
  logic CLK;
  logic RST;
  int   pass_cnt;
  int   total_cnt;

  fft_seq_div_if #(.WL(16)) bus ();

  fft_seq_div #(.WL(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Present an operation, wait for acceptance, then count edges after the
  // acceptance edge until out_valid is seen (k = 0 means right after it).
  task automatic do_op(input logic [31:0] n, input logic [15:0] d, output int k);
    int guard;
    bus.N = n;
    bus.D = d;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge CLK); #1;
      guard++;
    end
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 100) begin
      @(posedge CLK); #1;
      k++;
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge CLK); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.Q !== 16'd0 || bus.R !== 16'd0 ||
        bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL reset: ov=%b Q=%0d R=%0d dz=%b of=%b rdy=%b expected 0 0 0 0 0 1",
               bus.out_valid, bus.Q, bus.R, bus.div_by_zero, bus.overflow, bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int k;
    do_op(32'd1000, 16'd7, k);
    total_cnt++;
    if (k !== 17) $display("FAIL basic_latency: got %0d expected 17", k);
    else pass_cnt++;
    total_cnt++;
    if (bus.Q !== 16'd142 || bus.R !== 16'd6 || bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0)
      $display("FAIL basic_result: Q=%0d R=%0d dz=%b of=%b expected 142 6 0 0",
               $signed(bus.Q), $signed(bus.R), bus.div_by_zero, bus.overflow);
    else pass_cnt++;
    finish_op();
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL basic_release: out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_signs();
    int n_t [3] = '{-1000, 1000, -1000};
    int d_t [3] = '{7, -7, -7};
    int q_t [3] = '{-142, -142, 142};
    int r_t [3] = '{-6, 6, -6};
    int k;
    logic [15:0] eq, er;
    for (int i = 0; i < 3; i++) begin
      do_op(32'(n_t[i]), 16'(d_t[i]), k);
      eq = 16'(q_t[i]);
      er = 16'(r_t[i]);
      total_cnt++;
      if (k !== 17 || bus.Q !== eq || bus.R !== er || bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0)
        $display("FAIL sign_%0d: k=%0d Q=%0d R=%0d of=%b dz=%b expected 17 %0d %0d 0 0",
                 i, k, $signed(bus.Q), $signed(bus.R), bus.overflow, bus.div_by_zero, q_t[i], r_t[i]);
      else pass_cnt++;
      finish_op();
    end
  endtask

  task automatic test_div_zero();
    int k;
    do_op(32'd5, 16'd0, k);
    total_cnt++;
    if (k !== 0 || bus.div_by_zero !== 1'b1 || bus.overflow !== 1'b0 || bus.Q !== 16'd32767 || bus.R !== 16'd0)
      $display("FAIL dz_pos: k=%0d dz=%b of=%b Q=%0d R=%0d expected 0 1 0 32767 0",
               k, bus.div_by_zero, bus.overflow, $signed(bus.Q), $signed(bus.R));
    else pass_cnt++;
    finish_op();
    do_op(32'(-5), 16'd0, k);
    total_cnt++;
    if (k !== 0 || bus.div_by_zero !== 1'b1 || bus.Q !== 16'h8000 || bus.R !== 16'd0)
      $display("FAIL dz_neg: k=%0d dz=%b Q=%0d R=%0d expected 0 1 -32768 0",
               k, bus.div_by_zero, $signed(bus.Q), $signed(bus.R));
    else pass_cnt++;
    finish_op();
  endtask

  task automatic test_overflow();
    int n_t  [3] = '{65536, 32768, -32768};
    int k_t  [3] = '{0, 17, 17};
    logic [15:0] q_t [3] = '{16'h7fff, 16'h7fff, 16'h8000};
    logic        o_t [3] = '{1'b1, 1'b1, 1'b0};
    int k;
    for (int i = 0; i < 3; i++) begin
      do_op(32'(n_t[i]), 16'd1, k);
      total_cnt++;
      if (k !== k_t[i] || bus.Q !== q_t[i] || bus.overflow !== o_t[i] || bus.R !== 16'd0 || bus.div_by_zero !== 1'b0)
        $display("FAIL ovf_%0d: k=%0d Q=%h of=%b R=%0d dz=%b expected %0d %h %b 0 0",
                 i, k, bus.Q, bus.overflow, bus.R, bus.div_by_zero, k_t[i], q_t[i], o_t[i]);
      else pass_cnt++;
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int k;
    do_op(32'd1000, 16'd7, k);
    for (int i = 0; i < 5; i++) begin
      bus.N = 32'd77;
      bus.D = 16'd0;
      bus.in_valid = 1'b1;
      @(posedge CLK); #1;
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.Q !== 16'd142 || bus.R !== 16'd6 ||
          bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0)
        $display("FAIL hold_%0d: ov=%b rdy=%b Q=%0d R=%0d dz=%b of=%b expected 1 0 142 6 0 0",
                 i, bus.out_valid, bus.in_ready, $signed(bus.Q), $signed(bus.R), bus.div_by_zero, bus.overflow);
      else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    finish_op();
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL hold_release: out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_calc();
    int k;
    int stale;
    bus.N = 32'd12345;
    bus.D = 16'd1;
    bus.in_valid = 1'b1;
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    repeat (7) begin @(posedge CLK); #1; end
    RST = 1'b1;
    #1;
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.Q !== 16'd0 || bus.R !== 16'd0 ||
        bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0)
      $display("FAIL mid_reset: ov=%b Q=%0d R=%0d dz=%b of=%b expected all 0",
               bus.out_valid, bus.Q, bus.R, bus.div_by_zero, bus.overflow);
    else pass_cnt++;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b expected 1", bus.in_ready);
    else pass_cnt++;
    stale = 0;
    repeat (25) begin
      if (bus.out_valid !== 1'b0) stale++;
      @(posedge CLK); #1;
    end
    total_cnt++;
    if (stale !== 0) $display("FAIL mid_reset_stale: got %0d valid cycles expected 0", stale);
    else pass_cnt++;
    do_op(32'd100, 16'd3, k);
    total_cnt++;
    if (k !== 17 || bus.Q !== 16'd33 || bus.R !== 16'd1 || bus.overflow !== 1'b0)
      $display("FAIL after_reset: k=%0d Q=%0d R=%0d of=%b expected 17 33 1 0",
               k, $signed(bus.Q), $signed(bus.R), bus.overflow);
    else pass_cnt++;
    finish_op();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    RST = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.N = '0;
    bus.D = '0;
    #1;
    test_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/fft_seq_div.md
# fft_seq_div

Sequential signed divider that inverts the registered `Mult` product path: it takes a 2·WL-bit dividend (product width) and a WL-bit divisor and returns a WL-bit quotient and remainder. It is used in the FFT datapath for IFFT/normalisation scaling and magnitude division, where a full combinational divider is too large. It performs one restoring step per clock, uses a valid/ready handshake on both sides, and saturates on overflow or divide-by-zero.

## Interface
- `WL`, default 16: word length of divisor, quotient and remainder. The dividend is 2·WL bits.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `in_valid` in 1: dividend/divisor present.
- `in_ready` out 1: block accepts an operation. High only in IDLE.
- `N` in 2·WL: signed dividend.
- `D` in WL: signed divisor.
- `out_valid` out 1: result registers valid.
- `out_ready` in 1: consumer takes the result.
- `Q` out WL: signed quotient, truncated toward zero, saturated on error.
- `R` out WL: signed remainder, with the sign of N. R = 0 on any error.
- `div_by_zero` out 1: D was 0.
- `overflow` out 1: the true quotient does not fit in signed WL bits.

## Operation
- **States:** IDLE, CALC, SIGN, DONE.
- **IDLE**
  - `in_ready` = 1.
  - An operation is accepted on the edge where `in_valid` && `in_ready`.
  - On acceptance, latch sign(N), sign(D), |N| (unsigned, 2·WL bits) and |D| (unsigned, WL bits).
- **Early exits** (decided at the acceptance edge; IDLE → DONE):
  - D == 0: `div_by_zero` = 1. Q = 2^(WL-1)-1 if N ≥ 0, else -2^(WL-1). R = 0.
  - |N|[2WL-1:WL] ≥ |D|: `overflow` = 1. Q saturates by result sign (sign(N) XOR sign(D)): positive → 2^(WL-1)-1, negative → -2^(WL-1). R = 0.
- **Normal path:** IDLE → CALC.
  - Partial remainder (WL+1 bits) is initialised to |N| upper half.
  - A shift register holds |N| lower half.
  - Counter is initialised to 0.
- **CALC** (exactly WL cycles), each cycle:
  - remainder = {remainder, next dividend bit}.
  - If remainder ≥ |D|: subtract |D| and shift in quotient bit 1; else shift in 0.
  - After the WL-th step, go to SIGN.
- **SIGN** (one cycle):
  - Apply the quotient sign (sign(N) XOR sign(D)) and the remainder sign (sign(N)).
  - Signed range check on the unsigned quotient q:
    - Positive result with q ≥ 2^(WL-1): overflow, saturate to 2^(WL-1)-1.
    - Negative result with q > 2^(WL-1): overflow, saturate to -2^(WL-1).
    - Negative result with q = 2^(WL-1): legal, Q = -2^(WL-1).
  - Load Q, R and flags; go to DONE.
- **DONE**
  - `out_valid` = 1. Q, R and flags are held stable.
  - On the edge where `out_ready` = 1, go to IDLE. `out_valid` drops the next cycle.
- `in_valid` is ignored outside IDLE. There is no overlap between operations.
- **Reset** (any state, including mid-CALC):
  - Immediately: state = IDLE, `out_valid` = 0, Q = 0, R = 0, `div_by_zero` = 0, `overflow` = 0, counter = 0.
  - `in_ready` = 1 from the first cycle after reset.
  - Any in-flight operation is discarded and never emitted.

## Timing
- Acceptance edge t.
- Normal path:
  - CALC steps at edges t+1 … t+WL.
  - SIGN result registered at edge t+WL+1.
  - `out_valid` high in the cycle after edge t+WL+1. Latency is WL+1 edges (17 for WL=16).
- Early exits: `out_valid` high after edge t (latency 1).
- Minimum issue interval: WL+3 cycles (normal path, `out_ready` held high). Early exits: 2 cycles.
- `in_ready` is derived combinationally from state == IDLE. All other outputs are registered.
- A new op may be accepted on the edge immediately after the DONE→IDLE edge.

## Structure
- Shared package `fft_arith_pkg`:
  - state encoding localparams (IDLE, CALC, SIGN, DONE);
  - `SAT_MAX`/`SAT_MIN` as functions of WL;
  - width helper for the counter ($clog2(WL+1)).
- Sub-module `div_step`:
  - combinational, one restoring shift-compare-subtract step;
  - inputs: partial remainder, dividend bit, |D|;
  - outputs: next remainder, quotient bit.
  - Instantiated once and used iteratively by the FSM.

## Test plan
All scenarios use WL = 16.
- **Basic division:** N=1000, D=7.
  - Q=142, R=6, flags 0.
  - `out_valid` 17 edges after acceptance.
- **Sign combinations:**
  - N=-1000, D=7 → Q=-142, R=-6.
  - N=1000, D=-7 → Q=-142, R=6.
  - N=-1000, D=-7 → Q=142, R=-6.
- **Divide by zero:**
  - N=5, D=0 → `div_by_zero`=1, Q=32767, R=0, latency 1 edge.
  - N=-5, D=0 → Q=-32768.
- **Overflow boundaries:**
  - N=65536, D=1 → `overflow`=1, Q=32767 (early exit).
  - N=32768, D=1 → `overflow`=1, Q=32767 (SIGN stage).
  - N=-32768, D=1 → Q=-32768, no overflow.
- **Backpressure:** hold `out_ready` low for 5 cycles in DONE.
  - Q, R, flags and `out_valid` stay constant.
  - `in_ready`=0; `in_valid` pulses are ignored.
  - Release `out_ready` → IDLE next edge.
- **Reset mid-CALC:** assert `RST` at CALC step 8.
  - `out_valid`=0 and all outputs 0 at once; `in_ready`=1 after release.
  - No stale result appears.
  - Next op N=100, D=3 → Q=33, R=1.
